// File: rtl/rx_pkt_pkg.sv
// Shared types and helpers for the RX packet store: word geometry, FSM states and
// the QPSK hard-decision bit mapping.
package rx_pkt_pkg;

    localparam int unsigned SYM_PER_WORD = 16;
    localparam int unsigned WORD_W       = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_e;

    // The sign bit is the decision (1 = negative, zero decides 0); returned as {bit_q, bit_i}
    // so it drops straight into a 2-bit symbol slot of the packed word.
    function automatic logic [1:0] hard_bits(input logic sign_i, input logic sign_q);
        return {sign_q, sign_i};
    endfunction

endpackage

// File: rtl/rx_sfifo.sv
// Generic synchronous first-word-fall-through FIFO with registered occupancy count.
module rx_sfifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_rd   = rd_en_i && !empty_o;
    // A full FIFO still accepts a write when the same edge pops the head.
    assign do_wr   = wr_en_i && (!full || do_rd);
    assign count_o = count_q;
    // Output is forced to zero while empty so stale words never show on the bus.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_en_i && full && !rd_en_i));

endmodule

// File: rtl/rx_pkt_store.sv
// RX packet store: hard-decides QPSK symbols, packs 16 per 32-bit word, captures one
// fixed-length packet per admitted frame start and streams the words out over AXI-Stream.
module rx_pkt_store
    import rx_pkt_pkg::*;
#(
    parameter int unsigned SYM_W      = 16,
    parameter int unsigned PKT_SYMS   = 256,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [SYM_W-1:0] i_sym_i,
    input  logic [SYM_W-1:0] i_sym_q,
    input  logic             i_sym_vld,
    input  logic             i_frame_start,
    output logic [31:0]      o_m_tdata,
    output logic             o_m_tvalid,
    input  logic             i_m_tready,
    output logic             o_m_tlast,
    output logic             o_busy,
    output logic [15:0]      o_pkt_cnt,
    output logic [15:0]      o_drop_cnt
);

    localparam int unsigned WORDS = PKT_SYMS / SYM_PER_WORD;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SC_W  = $clog2(PKT_SYMS);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'(WORDS);
    localparam logic [SC_W-1:0]  LAST_SYM = SC_W'(PKT_SYMS - 1);

    state_e            state_q, state_d;
    logic [SC_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              fifo_wr;
    logic [WORD_W:0]   fifo_wdata;
    logic [WORD_W:0]   fifo_rdata;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  free_words;
    logic              start_req;
    logic              admit;
    logic [SC_W-1:0]   sym_base;
    logic [WORD_W-1:0] pack_base;
    logic [3:0]        slot;
    logic              unused_sym;

    // Only the sign bits carry the decision.
    assign unused_sym = ^{i_sym_i[SYM_W-2:0], i_sym_q[SYM_W-2:0]};

    // Admission: a whole packet must fit before capture starts, so no mid-packet overflow.
    assign free_words = DEPTH_C - fifo_count;
    assign start_req  = (state_q == IDLE) && i_frame_start && i_en;
    assign admit      = start_req && (free_words >= WORDS_C);

    // FSM, packer and counters next-state; the start cycle's symbol counts as symbol 0.
    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        pack_d     = pack_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        sym_base   = admit ? '0 : sym_cnt_q;
        pack_base  = admit ? '0 : pack_q;
        slot       = sym_base[3:0];

        if (start_req && !admit) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (admit) begin
            state_d   = CAPTURE;
            sym_cnt_d = '0;
            pack_d    = '0;
        end

        if ((state_q == CAPTURE || admit) && i_sym_vld) begin
            pack_d                  = pack_base;
            pack_d[{slot, 1'b0} +: 2] = hard_bits(i_sym_i[SYM_W-1], i_sym_q[SYM_W-1]);
            sym_cnt_d               = sym_base + SC_W'(1);
            if (slot == 4'd15) begin
                fifo_wr    = 1'b1;
                fifo_wdata = {(sym_base == LAST_SYM), pack_d};
                pack_d     = '0;
            end
            if (sym_base == LAST_SYM) begin
                state_d   = IDLE;
                sym_cnt_d = '0;
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
    end

    // Control and datapath registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            sym_cnt_q  <= '0;
            pack_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            pack_q     <= pack_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    rx_sfifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .wr_en_i (fifo_wr),
        .wdata_i (fifo_wdata),
        .rd_en_i (i_m_tready),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign o_m_tvalid = !fifo_empty;
    assign o_m_tlast  = fifo_rdata[WORD_W];
    assign o_m_tdata  = fifo_rdata[WORD_W-1:0];
    assign o_busy     = (state_q == CAPTURE);
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
